card_hit_detect: RTL
====================

// Module: card_hit_detect
// PURPOSE
//  Inverse of the card drawing path: maps a screen coordinate (mouse position) to the card grid.
//  On a left-click rising edge it resolves the click to a card index or a miss, using iterative subtraction.
//  It sits between the mouse interface and the game-logic FSM.
//  Its grid geometry must match the card drawing stages so that the drawn cards and the clickable areas coincide.
// PARAMETERS
//  X_POS   50   x of left edge of card (0,0), pixels
//  Y_POS   50   y of top edge of card (0,0), pixels
//  CARD_W  100  card width, pixels
//  CARD_H  140  card height, pixels
//  GAP_X   20   horizontal gap between cards
//  GAP_Y   20   vertical gap between cards
//  COLS    4    cards per row (>=1)
//  ROWS    4    card rows (>=1)
//  IDX_W   4    index width, = $clog2(ROWS*COLS)
// PORTS
//  pclk        in   1      pixel clock; all logic rising-edge
//  rst         in   1      synchronous, active-low reset (0 = reset)
//  enable      in   1      1 = clicks accepted; 0 aborts any scan in progress
//  xpos        in   12     mouse x, pclk domain
//  ypos        in   12     mouse y, pclk domain
//  mouse_left  in   1      left button level, pclk domain
//  busy        out  1      1 while a click is being resolved
//  hit_valid   out  1      1-cycle pulse: click landed on a card
//  miss        out  1      1-cycle pulse: click outside any card (gap, margin or beyond grid)
//  card_idx    out  IDX_W  row*COLS+col; valid with hit_valid, held until next result
// BEHAVIOUR
//  Reset (rst==0 at an edge): all outputs 0; FSM to IDLE; edge register cleared; latched x/y cleared.
//  Click event: mouse_left==1 && mouse_left_d==0 && enable && state==IDLE.
//   - mouse_left_d is always registered, including while busy.
//   - Holding the button yields exactly one event; edges that arrive while busy are dropped.
//  PITCH_X = CARD_W+GAP_X and PITCH_Y = CARD_H+GAP_Y, both 12-bit constants. All arithmetic is 12-bit unsigned; no multipliers.
//  FSM:
//   - IDLE:
//       on event: latch x,y; go to CAP.
//   - CAP:
//       if x<X_POS or y<Y_POS -> MISS.
//       else dx=x-X_POS, dy=y-Y_POS, col=0, row=0, base=0 -> SCAN_C.
//   - SCAN_C (one step/cycle):
//       if dx>=PITCH_X: dx-=PITCH_X, col+=1; if col was COLS-1 -> MISS (beyond grid).
//       else: if dx>=CARD_W -> MISS (gap); else -> SCAN_R.
//   - SCAN_R (one step/cycle):
//       if dy>=PITCH_Y: dy-=PITCH_Y, row+=1, base+=COLS; if row was ROWS-1 -> MISS.
//       else: if dy>=CARD_H -> MISS; else -> HIT.
//   - HIT:
//       card_idx<=base+col; hit_valid=1 for this cycle; -> IDLE.
//   - MISS:
//       miss=1 for this cycle; card_idx unchanged; -> IDLE.
//  busy is 1 in every state except IDLE.
//  Latency from the event edge to the result pulse: 3+col+row cycles; worst case COLS+ROWS+1.
//  hit_valid and miss are registered and mutually exclusive.
//  enable==0 in any non-IDLE state: go to IDLE next cycle with no pulse.
//  Reset mid-scan: no pulse is emitted; state is as after reset.
//  Boundaries:
//   - x==X_POS+CARD_W-1 is inside the card; x==X_POS+CARD_W is in the gap.
//   - The same inclusive/exclusive rule applies to y; it matches the drawing rule x>=X_POS, x<X_POS+W.
// STRUCTURE
//  Shared header _card_grid.vh:
//   - grid geometry defaults (X_POS..ROWS) and the PITCH_X/PITCH_Y macros, also used by the drawing stages;
//   - FSM state localparams (3-bit: IDLE, CAP, SCAN_C, SCAN_R, HIT, MISS).
//  One sub-module, rise_edge_det (pclk, rst, in -> pulse), for mouse_left.
//  The FSM, the subtract datapath and the output registers stay in this module.
// TESTING (defaults: PITCH_X=120, PITCH_Y=160)
//  1. Click at (60,60) -> hit_valid after 3 cycles, card_idx=0; busy=1 from the cycle after the edge until the pulse.
//  2. Click at (175,215) -> hit, card_idx=5. Click at (509,669) -> hit, card_idx=15, latency 9.
//  3. Clicks at (160,60) (x gap), (60,195) (y gap), (40,60) (left margin) and (530,60) (beyond col 3) -> miss each; card_idx unchanged.
//  4. Button held 50 cycles, plus a second edge issued while busy -> exactly one result pulse.
//  5. enable=0 during a click -> no pulse. enable dropped mid-SCAN_R at (509,669) -> busy drops, no pulse.
//  6. rst=0 for one cycle mid-SCAN_C -> all outputs 0 next cycle; a following click at (60,60) resolves normally to idx 0.

Source files
------------

// File: rtl/card_hit_detect_pkg.sv
// Grid geometry and FSM encoding for card click resolution.
// The geometry values must match the card drawing stages.
package card_hit_detect_pkg;

  localparam int unsigned XPos  = 50;
  localparam int unsigned YPos  = 50;
  localparam int unsigned CardW = 100;
  localparam int unsigned CardH = 140;
  localparam int unsigned GapX  = 20;
  localparam int unsigned GapY  = 20;
  localparam int unsigned Cols  = 4;
  localparam int unsigned Rows  = 4;

  localparam int unsigned CoordW = 12;
  localparam int unsigned IdxW   = (Rows * Cols > 1) ? $clog2(Rows * Cols) : 1;

  typedef logic [CoordW-1:0] coord_t;
  typedef logic [IdxW-1:0]   idx_t;

  localparam coord_t XPosC  = coord_t'(XPos);
  localparam coord_t YPosC  = coord_t'(YPos);
  localparam coord_t CardWC = coord_t'(CardW);
  localparam coord_t CardHC = coord_t'(CardH);
  localparam coord_t PitchX = coord_t'(CardW + GapX);
  localparam coord_t PitchY = coord_t'(CardH + GapY);

  localparam idx_t ColLast = idx_t'(Cols - 1);
  localparam idx_t RowLast = idx_t'(Rows - 1);
  localparam idx_t ColsIdx = idx_t'(Cols);

  typedef enum logic [2:0] {
    StIdle,
    StCap,
    StScanC,
    StScanR,
    StHit,
    StMiss
  } state_t;

endpackage

// File: rtl/rise_edge_det.sv
// Rising-edge detector: one-cycle pulse when the input goes 0 -> 1.
module rise_edge_det (
  input  logic pclk,
  input  logic rst,
  input  logic in,
  output logic pulse
);

  logic in_q;

  always_ff @(posedge pclk) begin
    if (!rst) begin
      in_q <= 1'b0;
    end else begin
      in_q <= in;
    end
  end

  assign pulse = in & ~in_q;

endmodule

// File: rtl/card_hit_detect.sv
// Resolves a mouse click to a card index or a miss by stepping through the grid
// one column, then one row, per cycle using pitch subtraction.
module card_hit_detect
  import card_hit_detect_pkg::*;
(
  input  logic            pclk,
  input  logic            rst,
  input  logic            enable,
  input  logic [11:0]     xpos,
  input  logic [11:0]     ypos,
  input  logic            mouse_left,
  output logic            busy,
  output logic            hit_valid,
  output logic            miss,
  output logic [IdxW-1:0] card_idx
);

  state_t state_q, state_d;
  coord_t dx_q, dx_d;
  coord_t dy_q, dy_d;
  idx_t   col_q, col_d;
  idx_t   row_q, row_d;
  idx_t   base_q, base_d;
  idx_t   card_idx_q, card_idx_d;
  logic   hit_valid_q, hit_valid_d;
  logic   miss_q, miss_d;
  logic   left_rise;
  logic   click;

  rise_edge_det u_left_edge (
    .pclk  (pclk),
    .rst   (rst),
    .in    (mouse_left),
    .pulse (left_rise)
  );

  assign click = left_rise & enable;

  always_comb begin
    state_d = state_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    col_d   = col_q;
    row_d   = row_q;
    base_d  = base_q;

    case (state_q)
      StIdle: begin
        if (click) begin
          dx_d    = xpos;
          dy_d    = ypos;
          state_d = StCap;
        end
      end
      StCap: begin
        if (dx_q < XPosC || dy_q < YPosC) begin
          state_d = StMiss;
        end else begin
          dx_d    = dx_q - XPosC;
          dy_d    = dy_q - YPosC;
          col_d   = '0;
          row_d   = '0;
          base_d  = '0;
          state_d = StScanC;
        end
      end
      StScanC: begin
        if (dx_q >= PitchX) begin
          dx_d  = dx_q - PitchX;
          col_d = col_q + idx_t'(1);
          if (col_q == ColLast) state_d = StMiss;
        end else if (dx_q >= CardWC) begin
          state_d = StMiss;
        end else begin
          state_d = StScanR;
        end
      end
      StScanR: begin
        // base tracks row*Cols so the final index needs only an add.
        if (dy_q >= PitchY) begin
          dy_d   = dy_q - PitchY;
          row_d  = row_q + idx_t'(1);
          base_d = base_q + ColsIdx;
          if (row_q == RowLast) state_d = StMiss;
        end else if (dy_q >= CardHC) begin
          state_d = StMiss;
        end else begin
          state_d = StHit;
        end
      end
      StHit:   state_d = StIdle;
      StMiss:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Dropping enable abandons the scan silently.
    if (state_q != StIdle && !enable) state_d = StIdle;

    hit_valid_d = (state_d == StHit);
    miss_d      = (state_d == StMiss);
    card_idx_d  = (state_d == StHit) ? (base_q + col_q) : card_idx_q;
  end

  always_ff @(posedge pclk) begin
    if (!rst) begin
      state_q     <= StIdle;
      dx_q        <= '0;
      dy_q        <= '0;
      col_q       <= '0;
      row_q       <= '0;
      base_q      <= '0;
      card_idx_q  <= '0;
      hit_valid_q <= 1'b0;
      miss_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      dx_q        <= dx_d;
      dy_q        <= dy_d;
      col_q       <= col_d;
      row_q       <= row_d;
      base_q      <= base_d;
      card_idx_q  <= card_idx_d;
      hit_valid_q <= hit_valid_d;
      miss_q      <= miss_d;
    end
  end

  assign busy      = (state_q != StIdle);
  assign hit_valid = hit_valid_q;
  assign miss      = miss_q;
  assign card_idx  = card_idx_q;

endmodule
